// File: rtl/cjb_status_cond_unit_v_if.sv
// Flag/condition bus between the arithmetic unit, control sequencer and the
// status/condition unit. The master side produces flags and requests; the
// slave side (the status unit) returns SR, carry and branch decisions.
interface cjb_status_cond_unit_v_if;
  logic [3:0] Arith_CNVZ;
  logic [3:0] Flag_Update;
  logic       Z_Chain;
  logic       SR_Load;
  logic [3:0] SR_Data_In;
  logic       Cond_Eval;
  logic [3:0] Cond_Sel;
  logic [3:0] SR_Out;
  logic       Carry_Out;
  logic       Cond_Valid;
  logic       Cond_True;

  modport master (
    output Arith_CNVZ, Flag_Update, Z_Chain, SR_Load, SR_Data_In,
           Cond_Eval, Cond_Sel,
    input  SR_Out, Carry_Out, Cond_Valid, Cond_True
  );

  modport slave (
    input  Arith_CNVZ, Flag_Update, Z_Chain, SR_Load, SR_Data_In,
           Cond_Eval, Cond_Sel,
    output SR_Out, Carry_Out, Cond_Valid, Cond_True
  );
endinterface

// File: rtl/cjb_status_cond_unit_v.sv
// Status/condition unit: holds the {C,N,V,Z} status register, applies masked
// and Z-chained flag updates or a context-restore load, and returns a
// registered branch decision one cycle after each evaluation strobe.
module cjb_status_cond_unit_v #(
  parameter bit FORWARD = 1'b0
) (
  input logic                         Clock,
  input logic                         Resetn,
  cjb_status_cond_unit_v_if.slave     bus
);

  // Flag bit positions inside SR {C,N,V,Z}
  localparam int C_BIT = 3;
  localparam int N_BIT = 2;
  localparam int V_BIT = 1;
  localparam int Z_BIT = 0;

  // Status register and evaluation result registers
  logic [3:0] sr_p1;
  logic       vld_p1;
  logic       true_p1;

  // Next-state SR and the SR image the condition is evaluated against
  logic [3:0] sr_nxt;
  logic [3:0] s_eval;

  // SR next state: restore load wins, otherwise per-flag masked update where a
  // chained Z accumulates equality across the bytes of a multi-byte operation.
  function automatic logic [3:0] sr_next_f(
    input logic [3:0] sr_cur,
    input logic       load,
    input logic [3:0] load_data,
    input logic [3:0] mask,
    input logic [3:0] cnvz,
    input logic       z_chain
  );
    logic [3:0] nxt;
    nxt = sr_cur;
    if (load) begin
      nxt = load_data;
    end else begin
      if (mask[C_BIT]) nxt[C_BIT] = cnvz[C_BIT];
      if (mask[N_BIT]) nxt[N_BIT] = cnvz[N_BIT];
      if (mask[V_BIT]) nxt[V_BIT] = cnvz[V_BIT];
      if (mask[Z_BIT]) begin
        if (z_chain) nxt[Z_BIT] = sr_cur[Z_BIT] & cnvz[Z_BIT];
        else         nxt[Z_BIT] = cnvz[Z_BIT];
      end
    end
    return nxt;
  endfunction

  // Branch condition decode. C=1 means no borrow, so HI/LS are the unsigned
  // greater / lower-or-same tests after a subtract.
  function automatic logic cond_f(
    input logic [3:0] sel,
    input logic [3:0] s
  );
    logic c, n, v, z;
    logic res;
    c = s[C_BIT];
    n = s[N_BIT];
    v = s[V_BIT];
    z = s[Z_BIT];
    case (sel)
      4'd0:    res = 1'b1;
      4'd1:    res = c;
      4'd2:    res = ~c;
      4'd3:    res = n;
      4'd4:    res = ~n;
      4'd5:    res = v;
      4'd6:    res = ~v;
      4'd7:    res = z;
      4'd8:    res = ~z;
      4'd9:    res = (n == v);
      4'd10:   res = (n != v);
      4'd11:   res = ~z & (n == v);
      4'd12:   res = z | (n != v);
      4'd13:   res = c & ~z;
      4'd14:   res = ~c | z;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Next-state SR and forwarding selection for the evaluation source
  always_comb begin
    sr_nxt = sr_next_f(sr_p1, bus.SR_Load, bus.SR_Data_In,
                       bus.Flag_Update, bus.Arith_CNVZ, bus.Z_Chain);
    s_eval = FORWARD ? sr_nxt : sr_p1;
  end

  // ---- stage p1: status register update ----
  // SR follows its next-state every edge; reset clears all flags
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) sr_p1 <= 4'b0000;
    else         sr_p1 <= sr_nxt;
  end

  // ---- stage p1: condition result ----
  // One valid pulse per strobe; the decision is held between strobes and a
  // reset discards any evaluation in flight.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      vld_p1  <= 1'b0;
      true_p1 <= 1'b0;
    end else begin
      vld_p1 <= bus.Cond_Eval;
      if (bus.Cond_Eval) true_p1 <= cond_f(bus.Cond_Sel, s_eval);
    end
  end

  assign bus.SR_Out     = sr_p1;
  assign bus.Carry_Out  = sr_p1[C_BIT];
  assign bus.Cond_Valid = vld_p1;
  assign bus.Cond_True  = true_p1;

endmodule
